// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_pkg : fetch-stage constants, fetch state encoding and PC helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam int unsigned INSTR_W          = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_HALT  = 3'd4
   } fetch_state_e;

   function automatic logic [31:0] pc_word_align(input logic [31:0] pc_in);
      return {pc_in[31:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_pc : program counter with hold / +4 / redirect next-PC selection.
// FETCH_ALIGN_CHECK_EN: keep raw redirect target and flag misalignment.
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_pc
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc_en,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc,
   output logic        misaligned
);

   logic [31:0] pc_d;
   logic [31:0] pc_q;
   logic [31:0] target;

`ifdef FETCH_ALIGN_CHECK_EN
   assign target     = redirect_pc;
   assign misaligned = redirect_en && (redirect_pc[1:0] != 2'b00);
`else
   // Low bits are dropped so every redirect lands on a word boundary.
   logic unused_low_bits;
   assign unused_low_bits = ^redirect_pc[1:0];
   assign target          = pc_word_align(redirect_pc);
   assign misaligned      = 1'b0;
`endif

   always_comb begin
      pc_d = pc_q;
      if (redirect_en) begin
         pc_d = target;
      end else if (inc_en) begin
         pc_d = pc_q + PC_STEP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_fetch_unit : fetch FSM, single-entry output slot and redirect squash.
// FETCH_ALIGN_CHECK_EN: misaligned redirect sets sticky fault and halts.
// Rev 1.0
// ----------------------------------------------------------------------------
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [31:0]        instr_pc,
   input  logic               instr_ready,
   output logic               fault
);

   fetch_state_e       state_q, state_d;
   logic               instr_valid_q, instr_valid_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [31:0]        instr_pc_q, instr_pc_d;
   logic               fault_q, fault_d;

   logic [31:0]        pc;
   logic               misaligned;
   logic               pc_inc;
   logic               slot_free;
   logic               req_fire;
   logic               redirect_en;

   fetch_pc #(
      .RESET_PC (RESET_PC)
   ) u_fetch_pc (
      .clk         (clk),
      .rst_n       (rst_n),
      .inc_en      (pc_inc),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .pc          (pc),
      .misaligned  (misaligned)
   );

   // A request may issue in the same cycle the decoder drains the slot.
   assign slot_free   = !instr_valid_q || instr_ready;
   assign imem_req    = (state_q == ST_REQ) && slot_free;
   assign imem_addr   = (state_q == ST_REQ) ? pc : 32'h0;
   assign req_fire    = imem_req && imem_gnt;
   assign redirect_en = redirect_valid && (state_q != ST_HALT);

   always_comb begin
      state_d       = state_q;
      instr_valid_d = instr_valid_q && !instr_ready;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      fault_d       = fault_q;
      pc_inc        = 1'b0;

      case (state_q)
         ST_IDLE:  state_d = ST_REQ;
         ST_REQ:   if (req_fire) state_d = ST_WAIT;
         ST_WAIT: begin
            if (imem_rvalid) begin
               state_d       = ST_REQ;
               instr_valid_d = 1'b1;
               instr_d       = imem_rdata;
               instr_pc_d    = pc;
               pc_inc        = 1'b1;
            end
         end
         ST_DRAIN: if (imem_rvalid) state_d = ST_REQ;
         ST_HALT:  instr_valid_d = 1'b0;
         default:  state_d = ST_IDLE;
      endcase

      // Redirect wins: drop the slot and any response, retarget the fetch.
      if (redirect_en) begin
         instr_valid_d = 1'b0;
         instr_d       = instr_q;
         instr_pc_d    = instr_pc_q;
         pc_inc        = 1'b0;
         case (state_q)
            ST_REQ:  state_d = req_fire ? ST_DRAIN : ST_REQ;
            ST_WAIT: state_d = imem_rvalid ? ST_REQ : ST_DRAIN;
            default: ;
         endcase
         if (misaligned) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         instr_valid_q <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= 32'h0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_valid_q <= instr_valid_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         fault_q       <= fault_d;
      end
   end

   assign instr_valid = instr_valid_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign fault       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// tb_instr_fetch_unit : directed stimulus, behavioural fetch-stream model
// and a per-cycle scoreboard for instr_fetch_unit.
module tb_instr_fetch_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b1;
   logic        fault;

   logic        gnt_en = 1'b1;
   int          lat = 1;
   int          n_total = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   assign imem_gnt = imem_req && gnt_en;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .fault          (fault)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input string nm);
      int k;
      k = 0;
      @(negedge clk);
      while (!(imem_req && imem_gnt) && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk(nm, {31'b0, imem_req && imem_gnt}, 32'd1);
   endtask

   task automatic wait_valid(input string nm);
      int k;
      k = 0;
      @(negedge clk);
      while (!instr_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk(nm, {31'b0, instr_valid}, 32'd1);
   endtask

   task automatic wait_req(input string nm);
      int k;
      k = 0;
      @(negedge clk);
      while (!imem_req && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk(nm, {31'b0, imem_req}, 32'd1);
   endtask

   // Memory: grant combinational when enabled, response 'lat' cycles later.
   initial begin : responder
      int          cnt;
      logic [31:0] a;
      cnt = 0;
      a   = 32'h0;
      forever begin
         @(negedge clk);
         if (rst_n && imem_req && imem_gnt) begin
            cnt = lat;
            a   = imem_addr;
         end
         @(posedge clk);
         #1;
         imem_rvalid = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(a);
            end
         end
      end
   end

   // Model: the stream of PCs that must reach the decoder, in order.
   initial begin : scoreboard
      logic [31:0] q[$];
      logic [31:0] exp_fetch;
      logic [31:0] hold_i;
      logic [31:0] hold_pc;
      logic [31:0] f;
      int          outst;
      bit          halted;
      bit          prev_redir;
      bit          prev_hold;
      exp_fetch  = RESET_PC_DEFAULT;
      hold_i     = 32'h0;
      hold_pc    = 32'h0;
      outst      = 0;
      halted     = 1'b0;
      prev_redir = 1'b0;
      prev_hold  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            exp_fetch  = RESET_PC_DEFAULT;
            outst      = 0;
            halted     = 1'b0;
            prev_redir = 1'b0;
            prev_hold  = 1'b0;
            continue;
         end
         if (prev_redir) chk("valid_after_redirect", {31'b0, instr_valid}, 32'd0);
         if (prev_hold) begin
            chk("hold_valid", {31'b0, instr_valid}, 32'd1);
            chk("hold_instr", instr, hold_i);
            chk("hold_pc", instr_pc, hold_pc);
         end
         if (halted) begin
            chk("halt_req", {31'b0, imem_req}, 32'd0);
            chk("halt_valid", {31'b0, instr_valid}, 32'd0);
         end
         if (imem_rvalid && outst > 0) outst--;
         if (instr_valid && instr_ready) begin
            if (q.size() == 0) begin
               chk("spurious_instr", instr_pc, 32'hDEAD_DEAD);
            end else begin
               f = q.pop_front();
               chk("deliver_pc", instr_pc, f);
               chk("deliver_instr", instr, mem_word(f));
            end
         end
         if (imem_req && imem_gnt) begin
            chk("fetch_addr", imem_addr, exp_fetch);
            chk("one_outstanding", outst, 32'd0);
            outst++;
            q.push_back(exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
         end
         prev_redir = 1'b0;
         prev_hold  = instr_valid && !instr_ready && !redirect_valid;
         hold_i     = instr;
         hold_pc    = instr_pc;
         if (redirect_valid && !halted) begin
            q.delete();
            prev_redir = 1'b1;
            prev_hold  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) halted = 1'b1;
            exp_fetch = redirect_pc;
`else
            exp_fetch = {redirect_pc[31:2], 2'b00};
`endif
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      #2 rst_n = 1'b0;
      #1;
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_fault", {31'b0, fault}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // Zero-wait memory, decoder always ready.
      @(negedge clk);
      chk("idle_req", {31'b0, imem_req}, 32'd0);
      @(negedge clk);
      chk("first_req", {31'b0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0040_0000);
      @(negedge clk);
      chk("wait_valid0", {31'b0, instr_valid}, 32'd0);
      @(negedge clk);
      chk("first_valid", {31'b0, instr_valid}, 32'd1);
      chk("first_pc", instr_pc, 32'h0040_0000);
      chk("first_instr", instr, 32'h1317_9BDF);
      chk("second_addr", imem_addr, 32'h0040_0004);
      for (int k = 1; k < 3; k++) begin
         @(negedge clk);
         chk("gap_valid", {31'b0, instr_valid}, 32'd0);
         @(negedge clk);
         chk("seq_valid", {31'b0, instr_valid}, 32'd1);
         chk("seq_pc", instr_pc, 32'h0040_0000 + 32'd4 * k);
      end

      // Back-pressure: slot full for 5 cycles.
      tick();
      instr_ready = 1'b0;
      @(negedge clk);
      chk("p2_inflight", {31'b0, instr_valid}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_req", {31'b0, imem_req}, 32'd0);
         chk("stall_valid", {31'b0, instr_valid}, 32'd1);
         chk("stall_pc", instr_pc, 32'h0040_000C);
         chk("stall_instr", instr, 32'h1317_9BD3);
      end
      tick();
      instr_ready = 1'b1;
      @(negedge clk);
      chk("resume_req", {31'b0, imem_req}, 32'd1);
      chk("resume_addr", imem_addr, 32'h0040_0010);
      wait_valid("resume_timeout");
      chk("resume_pc", instr_pc, 32'h0040_0010);

      // Redirect while waiting on a slow response.
      tick();
      lat = 3;
      wait_grant("p3_grant_timeout");
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0040_0100;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("p3_valid0", {31'b0, instr_valid}, 32'd0);
      chk("p3_drain_req", {31'b0, imem_req}, 32'd0);
      wait_grant("p3_regrant_timeout");
      chk("p3_target_addr", imem_addr, 32'h0040_0100);
      wait_valid("p3_valid_timeout");
      chk("p3_target_pc", instr_pc, 32'h0040_0100);

      // Redirect in the same cycle as the response.
      tick();
      lat = 1;
      wait_grant("p4_grant_timeout");
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0040_0200;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("p4_valid0", {31'b0, instr_valid}, 32'd0);
      chk("p4_req", {31'b0, imem_req}, 32'd1);
      chk("p4_addr", imem_addr, 32'h0040_0200);
      wait_valid("p4_valid_timeout");
      chk("p4_pc", instr_pc, 32'h0040_0200);

      // Grant withheld, redirect in REQ, then PC wrap.
      tick();
      gnt_en = 1'b0;
      wait_req("p5_req_timeout");
      chk("p5_addr", imem_addr, 32'h0040_0208);
      @(negedge clk);
      chk("p5_req_held", {31'b0, imem_req}, 32'd1);
      chk("p5_addr_held", imem_addr, 32'h0040_0208);
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("p5_retarget_req", {31'b0, imem_req}, 32'd1);
      chk("p5_retarget_addr", imem_addr, 32'hFFFF_FFFC);
      tick();
      gnt_en = 1'b1;
      wait_valid("p5_valid_timeout");
      chk("wrap_last_pc", instr_pc, 32'hFFFF_FFFC);
      chk("wrap_req", {31'b0, imem_req}, 32'd1);
      chk("wrap_addr", imem_addr, 32'h0000_0000);
      wait_valid("wrap_valid_timeout");
      chk("wrap_pc", instr_pc, 32'h0000_0000);

      // Misaligned redirect.
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0040_0102;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis_fault", {31'b0, fault}, 32'd1);
      chk("mis_valid", {31'b0, instr_valid}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("mis_req", {31'b0, imem_req}, 32'd0);
         chk("mis_fault_sticky", {31'b0, fault}, 32'd1);
      end
      tick();
      rst_n = 1'b0;
      #1;
      chk("mis_fault_clear", {31'b0, fault}, 32'd0);
      tick();
      rst_n = 1'b1;
      wait_valid("mis_restart_timeout");
      chk("mis_restart_pc", instr_pc, 32'h0040_0000);
`else
      chk("mis_fault", {31'b0, fault}, 32'd0);
      wait_valid("mis_valid_timeout");
      chk("mis_aligned_pc", instr_pc, 32'h0040_0100);
      chk("mis_aligned_instr", instr, 32'h1317_9ADF);
`endif

      // Asynchronous reset in the middle of a fetch.
      wait_grant("p7_grant_timeout");
      tick();
      rst_n = 1'b0;
      #1;
      chk("p7_valid", {31'b0, instr_valid}, 32'd0);
      chk("p7_req", {31'b0, imem_req}, 32'd0);
      chk("p7_pc", instr_pc, 32'h0);
      chk("p7_instr", instr, 32'h0);
      chk("p7_fault", {31'b0, fault}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("p7_idle_req", {31'b0, imem_req}, 32'd0);
      wait_valid("p7_valid_timeout");
      chk("p7_restart_pc", instr_pc, 32'h0040_0000);

      repeat (6) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
